// File: rtl/byte_serial_add_seq.sv
// Byte-serial wide adder sequencer: drives an external 8-bit adder LSB byte first and chains its carry.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN (adds the Sub port).
module byte_serial_add_seq #(
  parameter  int NBYTES = 4,
  localparam int W      = 8*NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic         Cin,
  input  logic [W-1:0] OpA,
  input  logic [W-1:0] OpB,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         Sub,
`endif
  output logic [7:0]   AddA,
  output logic [7:0]   AddB,
  output logic         AddCin,
  input  logic [7:0]   AddSum,
  input  logic         AddCout,
  output logic [W-1:0] Result,
  output logic         Cout,
  output logic         Busy,
  output logic         Done
);

  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, cout_q, busy_q, done_q;
  logic           sub_w, last_w;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_w = Sub;
`else
  assign sub_w = 1'b0;
`endif

  assign idx_d  = idx_q + 1'b1;
  assign last_w = (idx_q == IW'(NBYTES-1));

  // Operands shift down a byte per cycle, so the adder always sees bit 0 and
  // zeros are left behind once the last byte has been consumed.
  assign AddA   = a_q[7:0];
  assign AddB   = b_q[7:0];
  assign AddCin = carry_q & busy_q;
  assign Result = res_q;
  assign Cout   = cout_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q     <= OpA;
            // Subtract as A + ~B + 1: invert B up front, force carry-in.
            b_q     <= sub_w ? ~OpB : OpB;
            carry_q <= sub_w ? 1'b1 : Cin;
            idx_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[{idx_q, 3'b000} +: 8] <= AddSum;
          carry_q <= AddCout;
          idx_q   <= idx_d;
          a_q     <= a_q >> 8;
          b_q     <= b_q >> 8;
          if (last_w) begin
            cout_q  <= AddCout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Self-checking bench for byte_serial_add_seq: table vectors, corner sequences, random ops vs arithmetic model.
module tb_byte_serial_add_seq;

  localparam int NB = 4;
  localparam int W  = 8*NB;
  localparam logic [63:0] WMASK = (64'h1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, Start, Cin, tb_sub;
  logic [W-1:0] OpA, OpB, Result;
  logic [7:0]   AddA, AddB, AddSum;
  logic         AddCin, AddCout, Cout, Busy, Done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the external 8-bit adder.
  assign {AddCout, AddSum} = {1'b0, AddA} + {1'b0, AddB} + {8'd0, AddCin};

  byte_serial_add_seq #(.NBYTES(NB)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Cin(Cin), .OpA(OpA), .OpB(OpB),
`ifdef SERIAL_ADD_SUB_EN
    .Sub(tb_sub),
`endif
    .AddA(AddA), .AddB(AddB), .AddCin(AddCin), .AddSum(AddSum), .AddCout(AddCout),
    .Result(Result), .Cout(Cout), .Busy(Busy), .Done(Done)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] res;
    logic         cout;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs one operation, checking per-byte adder drive, Busy/Done timing and the
  // final sum against plain wide arithmetic. Optionally pokes Start mid-RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit poke,
                        output logic [W-1:0] got_res, output logic got_cout);
    logic [63:0] bb, c0, m, full;
    int done_at, ndone, nbusy, seq_bad;
    bb = sub ? (~{32'd0, b} & WMASK) : {32'd0, b};
    c0 = sub ? 64'd1 : {63'd0, cin};
    full = {32'd0, a} + bb + c0;
    @(negedge clk);
    OpA = a; OpB = b; Cin = cin; tb_sub = sub; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    done_at = -1; ndone = 0; nbusy = 0; seq_bad = 0;
    for (int c = 1; c <= NB + 4; c++) begin
      if (c > 1) @(negedge clk);
      if (Busy) begin
        if (nbusy < NB) begin
          m = (64'h1 << (8*nbusy)) - 1;
          if (AddA   !== 8'({32'd0, a} >> (8*nbusy))) seq_bad++;
          if (AddB   !== 8'(bb >> (8*nbusy)))         seq_bad++;
          if (AddCin !== 1'((({32'd0, a} & m) + (bb & m) + c0) >> (8*nbusy))) seq_bad++;
        end
        nbusy++;
      end else if (AddA !== 8'd0 || AddB !== 8'd0 || AddCin !== 1'b0) seq_bad++;
      if (Done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (poke && c == 2) begin Start = 1'b1; OpA = W'($urandom); OpB = W'($urandom); Cin = ~cin; end
      if (poke && c == 3) Start = 1'b0;
    end
    chk("done_latency", 64'(done_at), 64'(NB + 1));
    chk("done_width",   64'(ndone),   64'd1);
    chk("busy_cycles",  64'(nbusy),   64'(NB));
    chk("adder_drive",  64'(seq_bad), 64'd0);
    chk("model_result", {32'd0, Result}, full & WMASK);
    chk("model_cout",   {63'd0, Cout},   (full >> W) & 64'd1);
    got_res = Result; got_cout = Cout;
  endtask

  vec_t tbl[$];
  logic [W-1:0] r;
  logic         co;

  initial begin
    reset = 1'b1; Start = 1'b0; Cin = 1'b0; tb_sub = 1'b0; OpA = '0; OpB = '0;
    tbl.push_back('{32'h00000001, 32'h000000FF, 1'b0, 1'b0, 32'h00000100, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0});
    tbl.push_back('{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    tbl.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
    tbl.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
`endif

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_result", {32'd0, Result}, 64'd0);
    chk("rst_flags", {60'd0, Cout, Busy, Done, AddCin}, 64'd0);
    chk("rst_addab", {48'd0, AddA, AddB}, 64'd0);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0, r, co);
      chk($sformatf("tbl%0d_result", i), {32'd0, r}, {32'd0, tbl[i].res});
      chk($sformatf("tbl%0d_cout", i), {63'd0, co}, {63'd0, tbl[i].cout});
    end

    // Start during RUN is ignored; the following op runs normally.
    run_op(32'h12345678, 32'h87654321, 1'b0, 1'b0, 1'b1, r, co);
    chk("poke_result", {32'd0, r}, 64'h99999999);
    run_op(32'h00000001, 32'h000000FF, 1'b0, 1'b0, 1'b0, r, co);
    chk("after_poke_result", {32'd0, r}, 64'h00000100);

    // Reset mid-RUN after two bytes.
    @(negedge clk);
    OpA = 32'hFFFFFFFF; OpB = 32'h00000001; Cin = 1'b0; tb_sub = 1'b0; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_result", {32'd0, Result}, 64'd0);
    chk("midrst_flags", {60'd0, Cout, Busy, Done, AddCin}, 64'd0);
    chk("midrst_addab", {48'd0, AddA, AddB}, 64'd0);
    @(negedge clk);
    chk("midrst_idle", {63'd0, Busy}, 64'd0);
    run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, r, co);
    chk("postrst_result", {32'd0, r}, 64'h00010000);
    chk("postrst_cout", {63'd0, co}, 64'd0);

    for (int k = 0; k < 24; k++) begin
`ifdef SERIAL_ADD_SUB_EN
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), k[2], r, co);
`else
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, k[2], r, co);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
